// File: rtl/hw2_pipe_pkg.sv
// Shared definitions for the HW2 (A op B)*C pipeline with multiply-accumulate.
package hw2_pipe_pkg;

  localparam logic [1:0] OP_SUB     = 2'd0;
  localparam logic [1:0] OP_ADD     = 2'd1;
  localparam logic [1:0] OP_MAC_ADD = 2'd2;
  localparam logic [1:0] OP_MAC_SUB = 2'd3;

  // Per-stage load enables; a stage only captures data when its bit is set.
  typedef struct packed {
    logic s1;
    logic s2;
  } stage_en_t;

  // Default accumulator width: full product plus 8 bits of headroom.
  function automatic int acc_w_default(input int w);
    return 2 * w + 8;
  endfunction

endpackage

// File: rtl/hw2_pipe_if.sv
// Operand/result bus of the HW2 pipeline: valid/ready in, valid/ready out,
// plus accumulator clear and the accumulator status.
interface hw2_pipe_if
  import hw2_pipe_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = acc_w_default(W)
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [W-1:0]     c;
  logic [1:0]       op;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   result;
  logic [ACC_W-1:0] acc;
  logic             acc_ovf;

  // Operand source / result consumer side.
  modport master (
    output in_valid, a, b, c, op, acc_clr, out_ready,
    input  in_ready, out_valid, result, acc, acc_ovf
  );

  // Pipeline side.
  modport slave (
    input  in_valid, a, b, c, op, acc_clr, out_ready,
    output in_ready, out_valid, result, acc, acc_ovf
  );
endinterface

// File: rtl/hw2_pipe_acc.sv
// Signed accumulator with synchronous clear, add enable and sticky overflow.
// A clear coinciding with an add restarts the sum from the new addend.
module hw2_pipe_acc #(
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [ACC_W-1:0] add_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic                    ovf_o
);
  logic signed [ACC_W-1:0] acc_q, acc_d, base, sum;
  logic                    ovf_q, ovf_d, add_ovf;

  // Next state: clear first, then optionally add onto the (possibly cleared) base.
  always_comb begin
    base    = clr_i ? '0 : acc_q;
    sum     = base + add_i;
    add_ovf = (base[ACC_W-1] == add_i[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
    if (en_i) begin
      acc_d = sum;
      ovf_d = (clr_i ? 1'b0 : ovf_q) | add_ovf;
    end
  end

  // Accumulator and sticky flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/hw2_pipe_addmul_macc.sv
// Two-stage (A op B)*C pipeline with valid/ready backpressure and a MAC
// accumulator. S1 forms A+-B, S2 multiplies by C; registers load only on
// accepted data, so bubbles and stalls leave the datapath untouched.
module hw2_pipe_addmul_macc
  import hw2_pipe_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = acc_w_default(W)
) (
  input  logic     clk,
  input  logic     reset,
  hw2_pipe_if.slave bus
);
  // The sum is kept one bit wider than W+1 so that A+B never wraps
  // (255+255 must stay 510); A-B still sign-extends correctly.
  localparam int S_W = W + 2;
  localparam int P_W = 2 * W + 2;

  logic [2:1]              vld_pipe_q;   // [1]=S1 valid, [2]=out_valid
  logic [W-1:0]            c1_q;
  logic                    mac1_q;
  logic signed [S_W-1:0]   sum1_q, sum_d;
  logic [2*W-1:0]          result_q;
  logic signed [P_W-1:0]   p;
  logic signed [ACC_W-1:0] acc_s;
  logic                    ovf_s, adv, in_xfer, is_sub, is_mac;
  stage_en_t               en;

  // Handshake, operand pre-add and the S2 product.
  always_comb begin
    adv     = ~vld_pipe_q[2] | bus.out_ready;
    en.s2   = adv;
    en.s1   = ~vld_pipe_q[1] | adv;
    in_xfer = bus.in_valid & en.s1;
    is_sub  = (bus.op == OP_SUB) || (bus.op == OP_MAC_SUB);
    is_mac  = (bus.op == OP_MAC_ADD) || (bus.op == OP_MAC_SUB);
    sum_d   = is_sub ? $signed({2'b00, bus.a}) - $signed({2'b00, bus.b})
                     : $signed({2'b00, bus.a}) + $signed({2'b00, bus.b});
    p       = P_W'($signed({1'b0, c1_q})) * P_W'(sum1_q);
  end

  // Stage 1: valid follows the input when S1 may load; data only on a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q[1] <= 1'b0;
      c1_q          <= '0;
      mac1_q        <= 1'b0;
      sum1_q        <= '0;
    end else begin
      if (en.s1) vld_pipe_q[1] <= bus.in_valid;
      if (in_xfer) begin
        c1_q   <= bus.c;
        mac1_q <= is_mac;
        sum1_q <= sum_d;
      end
    end
  end

  // Stage 2: result captured only for valid items; a bubble just drops out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q[2] <= 1'b0;
      result_q      <= '0;
    end else if (en.s2) begin
      vld_pipe_q[2] <= vld_pipe_q[1];
      if (vld_pipe_q[1]) result_q <= p[2*W-1:0];
    end
  end

  hw2_pipe_acc #(.ACC_W(ACC_W)) u_acc (
    .clk   (clk),
    .reset (reset),
    .clr_i (bus.acc_clr),
    .en_i  (en.s2 & vld_pipe_q[1] & mac1_q),
    .add_i (ACC_W'(p)),
    .acc_o (acc_s),
    .ovf_o (ovf_s)
  );

  assign bus.in_ready  = en.s1;
  assign bus.out_valid = vld_pipe_q[2];
  assign bus.result    = result_q;
  assign bus.acc       = acc_s;
  assign bus.acc_ovf   = ovf_s;
endmodule
